ddr_rw_arb: RTL and testbench

- Arbiter sharing one DDR controller command port between the frame write buffer and the line read buffer.
- Each requester issues a one-cycle request pulse with address and length. The arbiter queues one request per side and selects one.
- It presents the selected request on a valid/ready command port and forwards the completion back to the owning requester.
- Read side has priority so the display does not underflow. A streak limit prevents write starvation.
- Only one DDR transaction is outstanding at a time.

---
 rtl/ddr_rw_arb.sv | 183 ++++++++++++++++++
 tb/tb_ddr_rw_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_arb.sv
// Arbitrates one DDR controller command port between the line read buffer and the frame write buffer.
// Reads win by default; a streak limit gives a pending write a turn. One transaction is outstanding at a time.
module ddr_rw_arb #(
    parameter int unsigned ADDR_WIDTH   = 27,
    parameter int unsigned LEN_WIDTH    = 16,
    parameter int unsigned RD_BURST_MAX = 4,
    parameter logic [15:0] TIMEOUT_CYC  = 16'd4096
) (
    input  logic                  ddr_clk,
    input  logic                  ddr_rstn,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic                  rd_rrdy,
    output logic                  rd_rdone,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    output logic                  wr_rrdy,
    output logic                  wr_rdone,
    output logic                  cmd_valid,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_ready,
    input  logic                  cmd_done,
    output logic                  busy,
    output logic [1:0]            err_flags,
    input  logic                  clr_err
);

    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TCNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  rd_pend_q, wr_pend_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [LEN_WIDTH-1:0]  rd_len_q, wr_len_q;
    logic [STREAK_W-1:0]   streak_q;
    logic [TCNT_W-1:0]     tcnt_q;
    logic                  done_q;

    logic done_rise_c, timeout_c, rd_accept_c, wr_accept_c, rd_ovf_c, wr_ovf_c;
    logic rd_grant_c, wr_grant_c, rd_release_c, wr_release_c, timeout_evt_c;
    logic in_wait_c, streak_full_c;
    logic [1:0] err_d;

    assign done_rise_c   = cmd_done & ~done_q;
    assign timeout_c     = (tcnt_q == TIMEOUT_CYC - 16'd1);
    assign in_wait_c     = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign rd_accept_c   = (state_q == RD_ISSUE) & cmd_ready;
    assign wr_accept_c   = (state_q == WR_ISSUE) & cmd_ready;
    assign rd_ovf_c      = rd_req & rd_pend_q & ~rd_accept_c;
    assign wr_ovf_c      = wr_req & wr_pend_q & ~wr_accept_c;
    assign streak_full_c = (streak_q >= STREAK_W'(RD_BURST_MAX));

    // State register
    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state and grant/release decode
    always_comb begin
        state_d       = state_q;
        rd_grant_c    = 1'b0;
        wr_grant_c    = 1'b0;
        rd_release_c  = 1'b0;
        wr_release_c  = 1'b0;
        timeout_evt_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_pend_q && (!wr_pend_q || !streak_full_c)) begin
                    state_d    = RD_ISSUE;
                    rd_grant_c = 1'b1;
                end else if (wr_pend_q) begin
                    state_d    = WR_ISSUE;
                    wr_grant_c = 1'b1;
                end
            end
            RD_ISSUE: if (cmd_ready) state_d = RD_WAIT;
            WR_ISSUE: if (cmd_ready) state_d = WR_WAIT;
            RD_WAIT: begin
                if (done_rise_c || timeout_c) begin
                    state_d       = IDLE;
                    rd_release_c  = 1'b1;
                    timeout_evt_c = ~done_rise_c;
                end
            end
            WR_WAIT: begin
                if (done_rise_c || timeout_c) begin
                    state_d       = IDLE;
                    wr_release_c  = 1'b1;
                    timeout_evt_c = ~done_rise_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky errors: clear first so a same-cycle set survives
    always_comb begin
        err_d    = clr_err ? 2'b00 : err_flags;
        err_d[0] = err_d[0] | timeout_evt_c;
        err_d[1] = err_d[1] | rd_ovf_c | wr_ovf_c;
    end

    // Request capture, streak, watchdog and done-edge tracking
    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            streak_q  <= '0;
            tcnt_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            if (rd_req && !rd_ovf_c) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= rd_addr;
                rd_len_q  <= rd_len;
            end else if (rd_accept_c) begin
                rd_pend_q <= 1'b0;
            end
            if (wr_req && !wr_ovf_c) begin
                wr_pend_q <= 1'b1;
                wr_addr_q <= wr_addr;
                wr_len_q  <= wr_len;
            end else if (wr_accept_c) begin
                wr_pend_q <= 1'b0;
            end
            if (wr_grant_c)                        streak_q <= '0;
            else if (rd_grant_c && !streak_full_c) streak_q <= streak_q + STREAK_W'(1);
            tcnt_q <= in_wait_c ? tcnt_q + TCNT_W'(1) : '0;
            done_q <= cmd_done;
        end
    end

    // Registered outputs
    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            rd_rrdy   <= 1'b0;
            wr_rrdy   <= 1'b0;
            rd_rdone  <= 1'b0;
            wr_rdone  <= 1'b0;
            busy      <= 1'b0;
            err_flags <= 2'b00;
        end else begin
            cmd_valid <= (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
            if (state_d == RD_ISSUE) begin
                cmd_write <= 1'b0;
                cmd_addr  <= rd_addr_q;
                cmd_len   <= rd_len_q;
            end else if (state_d == WR_ISSUE) begin
                cmd_write <= 1'b1;
                cmd_addr  <= wr_addr_q;
                cmd_len   <= wr_len_q;
            end
            rd_rrdy   <= rd_accept_c;
            wr_rrdy   <= wr_accept_c;
            rd_rdone  <= rd_release_c;
            wr_rdone  <= wr_release_c;
            busy      <= (state_d != IDLE);
            err_flags <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr_rw_arb.sv
// Directed bench for ddr_rw_arb: latency, overflow, watchdog, async reset, same-cycle requeue, read/write fairness.
module tb_ddr_rw_arb;

    localparam int unsigned AW = 27;
    localparam int unsigned LW = 16;

    logic          ddr_clk = 1'b0;
    logic          ddr_rstn;
    logic          rd_req, wr_req, cmd_ready, cmd_done, clr_err;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [LW-1:0] rd_len, wr_len;
    logic          rd_rrdy, rd_rdone, wr_rrdy, wr_rdone;
    logic          cmd_valid, cmd_write, busy;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [1:0]    err_flags;

    int n_cmp  = 0;
    int n_fail = 0;

    ddr_rw_arb #(
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .RD_BURST_MAX(4),
        .TIMEOUT_CYC (16'd64)
    ) dut (
        .ddr_clk  (ddr_clk),
        .ddr_rstn (ddr_rstn),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_len   (rd_len),
        .rd_rrdy  (rd_rrdy),
        .rd_rdone (rd_rdone),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_len   (wr_len),
        .wr_rrdy  (wr_rrdy),
        .wr_rdone (wr_rdone),
        .cmd_valid(cmd_valid),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_ready(cmd_ready),
        .cmd_done (cmd_done),
        .busy     (busy),
        .err_flags(err_flags),
        .clr_err  (clr_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_w;
        int   guard;

        ddr_rstn = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0; clr_err = 1'b0;
        rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
        tick(); tick();
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_flags), 32'd0);
        chk("rst_pulses", 32'({rd_rrdy, rd_rdone, wr_rrdy, wr_rdone}), 32'd0);
        ddr_rstn = 1'b1;
        tick();

        // single read: valid two cycles after the request, done edge releases
        rd_req = 1'b1; rd_addr = 27'h0001000; rd_len = 16'd60;
        tick();
        rd_req = 1'b0;
        chk("rd_lat1_valid", 32'(cmd_valid), 32'd0);
        tick();
        chk("rd_lat2_valid", 32'(cmd_valid), 32'd1);
        chk("rd_write", 32'(cmd_write), 32'd0);
        chk("rd_addr", 32'(cmd_addr), 32'h0001000);
        chk("rd_len", 32'(cmd_len), 32'd60);
        chk("rd_busy", 32'(busy), 32'd1);
        tick();
        chk("rd_hold_valid", 32'(cmd_valid), 32'd1);
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("rd_rrdy", 32'(rd_rrdy), 32'd1);
        chk("rd_valid_drop", 32'(cmd_valid), 32'd0);
        tick();
        chk("rd_rrdy_pulse", 32'(rd_rrdy), 32'd0);
        repeat (14) tick();
        chk("rd_no_early_done", 32'(rd_rdone), 32'd0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("rd_rdone", 32'(rd_rdone), 32'd1);
        chk("rd_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("rd_rdone_pulse", 32'(rd_rdone), 32'd0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("spurious_done", 32'({rd_rdone, wr_rdone, busy}), 32'd0);

        // overflow: second read while pending keeps the first command
        rd_req = 1'b1; rd_addr = 27'h0002000; rd_len = 16'd8;
        tick();
        rd_addr = 27'h0003000; rd_len = 16'd9;
        tick();
        rd_req = 1'b0;
        chk("ovf_valid", 32'(cmd_valid), 32'd1);
        chk("ovf_addr", 32'(cmd_addr), 32'h0002000);
        chk("ovf_err", 32'(err_flags), 32'd2);
        tick();
        chk("ovf_addr_hold", 32'(cmd_addr), 32'h0002000);
        chk("ovf_len_hold", 32'(cmd_len), 32'd8);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(err_flags), 32'd0);
        rd_req = 1'b1; rd_addr = 27'h0005555; clr_err = 1'b1;
        tick();
        rd_req = 1'b0; clr_err = 1'b0;
        chk("ovf_set_wins", 32'(err_flags), 32'd2);
        chk("ovf_addr_hold2", 32'(cmd_addr), 32'h0002000);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("ovf_rrdy", 32'(rd_rrdy), 32'd1);
        chk("ovf_clr2", 32'(err_flags), 32'd0);
        repeat (3) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("ovf_rdone", 32'(rd_rdone), 32'd1);
        tick();
        chk("ovf_no_requeue", 32'(cmd_valid), 32'd0);

        // watchdog on a write that never completes
        wr_req = 1'b1; wr_addr = 27'h0004000; wr_len = 16'd32;
        tick();
        wr_req = 1'b0;
        tick();
        chk("to_valid", 32'(cmd_valid), 32'd1);
        chk("to_write", 32'(cmd_write), 32'd1);
        chk("to_addr", 32'(cmd_addr), 32'h0004000);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("to_wrrdy", 32'(wr_rrdy), 32'd1);
        repeat (63) tick();
        chk("to_before", 32'({wr_rdone, busy, err_flags}), 32'b0100);
        tick();
        chk("to_wrdone", 32'(wr_rdone), 32'd1);
        chk("to_err", 32'(err_flags), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        rd_req = 1'b1; rd_addr = 27'h0006000; rd_len = 16'd4;
        tick();
        rd_req = 1'b0;
        tick();
        chk("to_rd_valid", 32'({cmd_valid, cmd_write}), 32'b10);
        chk("to_rd_addr", 32'(cmd_addr), 32'h0006000);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("to_rd_rrdy", 32'(rd_rrdy), 32'd1);
        tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("to_rd_rdone", 32'(rd_rdone), 32'd1);
        chk("to_err_sticky", 32'(err_flags), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_err_clr", 32'(err_flags), 32'd0);

        // request lands in the same cycle its predecessor is accepted
        rd_req = 1'b1; rd_addr = 27'h0007000; rd_len = 16'd5;
        tick();
        rd_req = 1'b0;
        tick();
        chk("sc_addr1", 32'(cmd_addr), 32'h0007000);
        cmd_ready = 1'b1; rd_req = 1'b1; rd_addr = 27'h0008000; rd_len = 16'd6;
        tick();
        cmd_ready = 1'b0; rd_req = 1'b0;
        chk("sc_rrdy", 32'(rd_rrdy), 32'd1);
        chk("sc_no_ovf", 32'(err_flags), 32'd0);
        tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("sc_rdone", 32'({rd_rdone, busy, cmd_valid}), 32'b100);
        tick();
        chk("sc_requeue_valid", 32'(cmd_valid), 32'd1);
        chk("sc_requeue_addr", 32'(cmd_addr), 32'h0008000);
        chk("sc_requeue_len", 32'(cmd_len), 32'd6);

        // async reset while in RD_WAIT with a write queued
        cmd_ready = 1'b1; wr_req = 1'b1; wr_addr = 27'h0009000; wr_len = 16'd7;
        tick();
        cmd_ready = 1'b0; wr_req = 1'b0;
        chk("ar_pre_rrdy", 32'({rd_rrdy, busy}), 32'b11);
        #3;
        ddr_rstn = 1'b0;
        #1;
        chk("ar_outputs", 32'({rd_rrdy, rd_rdone, wr_rrdy, wr_rdone, cmd_valid, busy}), 32'd0);
        chk("ar_addr", 32'(cmd_addr), 32'd0);
        tick();
        ddr_rstn = 1'b1; cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("ar_no_rdone", 32'({rd_rdone, wr_rdone}), 32'd0);
        repeat (3) tick();
        chk("ar_pend_cleared", 32'({cmd_valid, busy, rd_rdone, wr_rdone}), 32'd0);

        // contention: both sides kept pending, expect R,R,R,R,W repeating
        rd_req = 1'b1; rd_addr = 27'h000A000; rd_len = 16'd16;
        wr_req = 1'b1; wr_addr = 27'h000B000; wr_len = 16'd16;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_w = ((i % 5) == 4);
            guard = 0;
            while (!cmd_valid && guard < 20) begin
                tick();
                guard++;
            end
            chk("cont_valid", 32'(cmd_valid), 32'd1);
            chk($sformatf("cont_grant%0d", i), 32'(cmd_write), 32'(exp_w));
            cmd_ready = 1'b1;
            if (exp_w) wr_req = 1'b1;
            else       rd_req = 1'b1;
            tick();
            cmd_ready = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
            chk($sformatf("cont_rrdy%0d", i), 32'({rd_rrdy, wr_rrdy}), exp_w ? 32'b01 : 32'b10);
            repeat (17) tick();
            cmd_done = 1'b1;
            tick();
            cmd_done = 1'b0;
            chk($sformatf("cont_rdone%0d", i), 32'({rd_rdone, wr_rdone}), exp_w ? 32'b01 : 32'b10);
        end
        chk("cont_no_err", 32'(err_flags), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
